eth_gmii_tx_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_gmii_tx_framer.sv | 192 +++++++++++++++++++
 tb/tb_eth_gmii_tx_framer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet transmit-path definitions.
//
// Holds the preamble/SFD constants, the default inter-frame gap and the
// state encoding of the GMII transmit framer.
package eth_pkg;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
    localparam int         ETH_PREAMBLE_LEN  = 7;
    localparam int         ETH_IFG_DEFAULT   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_IFG
    } framer_state_t;

endpackage

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer.
//
// Takes a complete AXI4-Stream frame (payload with FCS already appended)
// and drives it onto GMII: 7 preamble bytes, the SFD, then the frame bytes
// back to back, followed by an inter-frame gap of max(ifg_delay, IFG_MIN)
// idle byte times. If the source runs dry mid-frame, one 0x00 byte is sent
// to truncate the frame, underflow pulses, and the rest of the source frame
// is drained without being transmitted.
//
// Optional build macro ETH_GMII_TX_ER_EN: when defined, gmii_tx_er flags the
// underflow byte and the last byte of a frame marked bad via s_axis_tuser.
// When undefined, gmii_tx_er stays 0 and s_axis_tuser is ignored.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axis_tdata    frame byte            s_axis_tvalid / s_axis_tready
//   s_axis_tlast    last frame byte       s_axis_tuser (bad frame, with tlast)
//   gmii_txd        GMII data             gmii_tx_en / gmii_tx_er
//   ifg_delay       requested IFG in byte times, sampled on IFG entry
//   busy            high whenever the framer is not idle
//   underflow       one-cycle pulse when the source underflows mid-frame
module eth_gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int IFG_MIN = ETH_IFG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    input  logic [7:0] ifg_delay,
    output logic       busy,
    output logic       underflow
);

`ifdef ETH_GMII_TX_ER_EN
    localparam logic TX_ER_EN = 1'b1;
`else
    localparam logic TX_ER_EN = 1'b0;
`endif

    framer_state_t state, state_nxt;
    logic [3:0]    pre_cnt, pre_cnt_nxt;
    logic [7:0]    ifg_cnt, ifg_cnt_nxt;

    logic          tready_nxt;
    logic [7:0]    txd_nxt;
    logic          tx_en_nxt;
    logic          tx_er_nxt;
    logic          underflow_nxt;
    logic          data_phase;

    function automatic logic [7:0] clamp_ifg(input logic [7:0] req);
        if (req < 8'(IFG_MIN)) begin
            return 8'(IFG_MIN);
        end
        return req;
    endfunction

    always_comb begin
        state_nxt     = state;
        pre_cnt_nxt   = pre_cnt;
        ifg_cnt_nxt   = ifg_cnt;
        tready_nxt    = 1'b0;
        txd_nxt       = 8'h00;
        tx_en_nxt     = 1'b0;
        tx_er_nxt     = 1'b0;
        underflow_nxt = 1'b0;
        data_phase    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_nxt   = ST_PREAMBLE;
                    pre_cnt_nxt = 4'd1;
                    txd_nxt     = ETH_PREAMBLE_BYTE;
                    tx_en_nxt   = 1'b1;
                end
            end

            // pre_cnt counts the preamble/SFD bytes already on the wire. The
            // cycle in which the SFD is on the wire already has tready high,
            // so it accepts the first frame byte exactly like a payload cycle.
            ST_PREAMBLE: begin
                if (pre_cnt < 4'(ETH_PREAMBLE_LEN)) begin
                    txd_nxt     = ETH_PREAMBLE_BYTE;
                    tx_en_nxt   = 1'b1;
                    pre_cnt_nxt = pre_cnt + 4'd1;
                end else if (pre_cnt == 4'(ETH_PREAMBLE_LEN)) begin
                    txd_nxt     = ETH_SFD_BYTE;
                    tx_en_nxt   = 1'b1;
                    tready_nxt  = 1'b1;
                    pre_cnt_nxt = pre_cnt + 4'd1;
                end else begin
                    data_phase = 1'b1;
                end
            end

            ST_PAYLOAD: begin
                data_phase = 1'b1;
            end

            // The gap was loaded at the underflow byte, so it keeps running
            // while the remainder of the source frame is discarded.
            ST_DRAIN: begin
                tready_nxt = 1'b1;
                if (ifg_cnt != 8'd0) begin
                    ifg_cnt_nxt = ifg_cnt - 8'd1;
                end
                if (s_axis_tvalid && s_axis_tlast) begin
                    tready_nxt = 1'b0;
                    if (ifg_cnt > 8'd1) begin
                        state_nxt = ST_IFG;
                    end else begin
                        state_nxt   = ST_IDLE;
                        ifg_cnt_nxt = 8'd0;
                    end
                end
            end

            // The cycle that shows the last byte is the first IFG cycle, and
            // the IDLE cycle that samples the next tvalid is the last idle
            // byte time, which together give exactly ifg_cnt idle bytes.
            ST_IFG: begin
                if (ifg_cnt <= 8'd1) begin
                    state_nxt   = ST_IDLE;
                    ifg_cnt_nxt = 8'd0;
                end else begin
                    ifg_cnt_nxt = ifg_cnt - 8'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (data_phase) begin
            pre_cnt_nxt = 4'd0;
            tx_en_nxt   = 1'b1;
            if (s_axis_tvalid) begin
                txd_nxt    = s_axis_tdata;
                tready_nxt = 1'b1;
                state_nxt  = ST_PAYLOAD;
                if (s_axis_tlast) begin
                    tready_nxt  = 1'b0;
                    tx_er_nxt   = TX_ER_EN & s_axis_tuser;
                    state_nxt   = ST_IFG;
                    ifg_cnt_nxt = clamp_ifg(ifg_delay);
                end
            end else begin
                txd_nxt       = 8'h00;
                tx_er_nxt     = TX_ER_EN;
                underflow_nxt = 1'b1;
                tready_nxt    = 1'b1;
                state_nxt     = ST_DRAIN;
                ifg_cnt_nxt   = clamp_ifg(ifg_delay);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pre_cnt       <= 4'd0;
            ifg_cnt       <= 8'd0;
            s_axis_tready <= 1'b0;
            gmii_txd      <= 8'h00;
            gmii_tx_en    <= 1'b0;
            gmii_tx_er    <= 1'b0;
            busy          <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            state         <= state_nxt;
            pre_cnt       <= pre_cnt_nxt;
            ifg_cnt       <= ifg_cnt_nxt;
            s_axis_tready <= tready_nxt;
            gmii_txd      <= txd_nxt;
            gmii_tx_en    <= tx_en_nxt;
            gmii_tx_er    <= tx_er_nxt;
            busy          <= (state_nxt != ST_IDLE);
            underflow     <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Self-checking bench for eth_gmii_tx_framer.
//
// The stimulus side pushes the expected GMII byte stream and the expected
// inter-frame gap of each frame into queues; a negedge monitor pops and
// compares them as the DUT transmits.
module tb_eth_gmii_tx_framer;

`ifdef ETH_GMII_TX_ER_EN
    localparam logic TB_ER = 1'b1;
`else
    localparam logic TB_ER = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] ifg_delay;
    logic       busy;
    logic       underflow;

    eth_gmii_tx_framer #(.IFG_MIN(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .ifg_delay    (ifg_delay),
        .busy         (busy),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       er;
        logic       uf;
    } exp_t;

    exp_t       exp_q[$];
    int         gap_q[$];
    int         n_checks;
    int         n_fail;
    int         rdy_cycles;
    bit         mon_on;
    logic [7:0] fb [0:7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic er, input logic uf);
        exp_t e;
        e.d  = d;
        e.er = er;
        e.uf = uf;
        exp_q.push_back(e);
    endtask

    // Expected preamble + SFD, plus the gap expected before this frame
    // (-1 when the frame does not follow the previous one back to back).
    task automatic push_header(input int gap);
        gap_q.push_back(gap);
        for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0, 1'b0);
        push_byte(8'hD5, 1'b0, 1'b0);
    endtask

    task automatic start_frame(input int n, input logic user, input int gap);
        push_header(gap);
        for (int i = 0; i < n; i++)
            push_byte(fb[i], (i == n - 1) ? (TB_ER & user) : 1'b0, 1'b0);
    endtask

    task automatic axis_beat(input logic [7:0] d, input logic last, input logic user);
        int waited;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!s_axis_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_axis_tready) chk("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int n, input logic user);
        for (int i = 0; i < n; i++)
            axis_beat(fb[i], (i == n - 1), (i == n - 1) ? user : 1'b0);
    endtask

    task automatic send_frame(input int n, input logic user, input int gap);
        start_frame(n, user, gap);
        drive_frame(n, user);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected byte per tx_en cycle and one expected gap
    // per rising edge of tx_en.
    initial begin
        int   gap_cnt;
        logic prev_en;
        exp_t e;
        int   g;
        gap_cnt = 0;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (s_axis_tready) rdy_cycles++;
                if (gmii_tx_en) begin
                    if (!prev_en) begin
                        if (gap_q.size() == 0) begin
                            chk("gap_unexpected", 32'd1, 32'd0);
                        end else begin
                            g = gap_q.pop_front();
                            if (g >= 0) chk("ifg_gap", gap_cnt, g);
                        end
                    end
                    gap_cnt = 0;
                    if (exp_q.size() == 0) begin
                        chk("byte_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txd", gmii_txd, e.d);
                        chk("tx_er", gmii_tx_er, e.er);
                        chk("underflow", underflow, e.uf);
                        chk("busy_tx", busy, 1'b1);
                    end
                end else begin
                    gap_cnt++;
                    chk("idle_tx_er", gmii_tx_er, 1'b0);
                    chk("idle_underflow", underflow, 1'b0);
                end
                prev_en = gmii_tx_en;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rdy_cycles    = 0;
        mon_on        = 1'b0;
        rst           = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        ifg_delay     = 8'd12;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_txd", gmii_txd, 8'h00);
        chk("rst_tx_en", gmii_tx_en, 1'b0);
        chk("rst_tx_er", gmii_tx_er, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        idle(2);

        // Basic 4-byte frame; tready must be high only for the 4 accepts.
        rdy_cycles = 0;
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        send_frame(4, 1'b0, -1);
        idle(1);
        @(negedge clk);
        chk("busy_in_ifg", busy, 1'b1);
        idle(20);
        chk("tready_cycles", rdy_cycles, 4);

        // Back-to-back frames: gap 12, clamped 5->12, 20, and a mid-IFG
        // change of ifg_delay that must not alter the running gap.
        ifg_delay = 8'd12;
        fb[0] = 8'hA1; fb[1] = 8'hA2; fb[2] = 8'hA3;
        send_frame(3, 1'b0, -1);
        ifg_delay = 8'd5;
        fb[0] = 8'hB1; fb[1] = 8'hB2;
        send_frame(2, 1'b0, 12);
        ifg_delay = 8'd20;
        fb[0] = 8'hC1; fb[1] = 8'hC2; fb[2] = 8'hC3;
        send_frame(3, 1'b0, 12);
        fb[0] = 8'hD1; fb[1] = 8'hD2;
        fork
            send_frame(2, 1'b0, 20);
            begin
                repeat (5) @(posedge clk);
                #2;
                ifg_delay = 8'd3;
            end
        join
        fb[0] = 8'hE1; fb[1] = 8'hE2; fb[2] = 8'hE3; fb[3] = 8'hE4;
        send_frame(4, 1'b0, 12);
        ifg_delay = 8'd12;
        idle(30);

        // Underflow after AA BB, then CC DD drained; next frame is a
        // 1-byte bad frame (tuser) starting back to back.
        push_header(-1);
        push_byte(8'hAA, 1'b0, 1'b0);
        push_byte(8'hBB, 1'b0, 1'b0);
        push_byte(8'h00, TB_ER, 1'b1);
        axis_beat(8'hAA, 1'b0, 1'b0);
        axis_beat(8'hBB, 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        axis_beat(8'hCC, 1'b0, 1'b0);
        axis_beat(8'hDD, 1'b1, 1'b0);
        fb[0] = 8'h77;
        send_frame(1, 1'b1, 12);
        idle(30);

        // Reset during the 4th preamble byte.
        push_header(-1);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        s_axis_tdata  = 8'h99;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_tx_en", gmii_tx_en, 1'b0);
        chk("rst_mid_tx_er", gmii_tx_er, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_leftover", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // After reset the preamble starts one cycle after tvalid.
        fb[0] = 8'h5A; fb[1] = 8'hA5;
        start_frame(2, 1'b0, -1);
        s_axis_tdata  = fb[0];
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        chk("post_rst_lat0", gmii_tx_en, 1'b0);
        @(negedge clk);
        chk("post_rst_lat1", gmii_tx_en, 1'b1);
        drive_frame(2, 1'b0);
        idle(30);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("gap_q_drained", gap_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
